// File: rtl/watch_pkg.sv
// Shared types and constants for the multiplexed HH-MM-SS seven-segment display.
package watch_pkg;

  typedef enum logic [0:0] {
    IDLE,
    CONV
  } state_e;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit codes beyond 0-9 understood by seg7_decode
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_E     = 4'd11;
  localparam logic [3:0] CODE_BLANK = 4'd12;

  function automatic logic [7:0] fmt_field(input logic [7:0] bcd, input logic err);
    return err ? {CODE_E, CODE_E} : bcd;
  endfunction

endpackage

// File: rtl/watch_display_if.sv
// Time-in / display-out bundle; master drives the time, slave drives the display.
interface watch_display_if
  import watch_pkg::*;
;
  logic [5:0]            horas;
  logic [5:0]            minutos;
  logic [5:0]            segundos;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (output horas, minutos, segundos, input an, seg, dp);
  modport slave  (input horas, minutos, segundos, output an, seg, dp);
endinterface

// File: rtl/seg7_decode.sv
// Maps a 4-bit digit code to active-low segments {g,f,e,d,c,b,a}.
module seg7_decode
  import watch_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = 7'b1000000;
      4'd1:      seg = 7'b1111001;
      4'd2:      seg = 7'b0100100;
      4'd3:      seg = 7'b0110000;
      4'd4:      seg = 7'b0011001;
      4'd5:      seg = 7'b0010010;
      4'd6:      seg = 7'b0000010;
      4'd7:      seg = 7'b1111000;
      4'd8:      seg = 7'b0000000;
      4'd9:      seg = 7'b0010000;
      CODE_DASH: seg = SEG_DASH;
      CODE_E:    seg = SEG_E;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/watch_display.sv
// Eight-digit scanned HH-MM-SS display with a shared sequential double-dabble converter.
module watch_display
  import watch_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input logic            clk,
  input logic            rst_n,
  watch_display_if.slave bus
);

  localparam int unsigned CntW   = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIGIT_CYCLES - 1);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  state_e           state_q, state_d;
  logic [17:0]      snap_q, snap_d;
  logic [13:0]      shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       field_q, field_d;
  logic [7:0]       h_bcd_q, h_bcd_d;
  logic [7:0]       m_bcd_q, m_bcd_d;
  logic [5:0][3:0]  disp_q, disp_d;

  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;

  logic [17:0] cur_time;
  logic [3:0]  tens_adj, units_adj;
  logic [13:0] shift_step;
  logic [3:0]  code;
  logic [6:0]  seg_dec;

  assign cur_time = {bus.horas, bus.minutos, bus.segundos};

  // shift_q = {tens, units, remaining binary}; add-3 then shift left
  always_comb begin
    tens_adj   = (shift_q[13:10] >= 4'd5) ? shift_q[13:10] + 4'd3 : shift_q[13:10];
    units_adj  = (shift_q[9:6] >= 4'd5) ? shift_q[9:6] + 4'd3 : shift_q[9:6];
    shift_step = 14'({tens_adj, units_adj, shift_q[5:0], 1'b0});
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    field_d = field_q;
    h_bcd_d = h_bcd_q;
    m_bcd_d = m_bcd_q;
    disp_d  = disp_q;
    unique case (state_q)
      IDLE: begin
        if (cur_time != snap_q) begin
          snap_d  = cur_time;
          shift_d = {8'h00, bus.horas};
          bit_d   = '0;
          field_d = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        shift_d = shift_step;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd5) begin
          bit_d   = '0;
          field_d = field_q + 2'd1;
          unique case (field_q)
            2'd0: begin
              h_bcd_d = shift_step[13:6];
              shift_d = {8'h00, snap_q[11:6]};
            end
            2'd1: begin
              m_bcd_d = shift_step[13:6];
              shift_d = {8'h00, snap_q[5:0]};
            end
            default: begin
              // All six digits land together so the display never mixes old and new
              disp_d  = {fmt_field(h_bcd_q, snap_q[17:12] > 6'd23),
                         fmt_field(m_bcd_q, snap_q[11:6] > 6'd59),
                         fmt_field(shift_step[13:6], snap_q[5:0] > 6'd59)};
              state_d = IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // an[7]..an[0] = H tens, H units, dash, M tens, M units, dash, S tens, S units
  always_comb begin
    code = CODE_BLANK;
    unique case (idx_q)
      3'd7:    code = disp_q[5];
      3'd6:    code = disp_q[4];
      3'd5:    code = CODE_DASH;
      3'd4:    code = disp_q[3];
      3'd3:    code = disp_q[2];
      3'd2:    code = CODE_DASH;
      3'd1:    code = disp_q[1];
      default: code = disp_q[0];
    endcase
  end

  seg7_decode u_seg7_decode (
    .code (code),
    .seg  (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      field_q <= '0;
      h_bcd_q <= '0;
      m_bcd_q <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      field_q <= field_d;
      h_bcd_q <= h_bcd_d;
      m_bcd_q <= m_bcd_d;
      disp_q  <= disp_d;
      if (cnt_q == CntMax) begin
        cnt_q <= '0;
        idx_q <= idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      an_q  <= ~(NUM_DIGITS'(1) << idx_q);
      seg_q <= seg_dec;
      dp_q  <= 1'b1;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
